dr_tx_bridge: RTL and testbench
===============================

# dr_tx_bridge

Clocked-to-dual-rail injector that feeds the first asynchronous dual-rail stage of the pipeline. It accepts words from the synchronous domain over a valid/ready handshake, encodes each bit as a dual-rail pair, and drives a 4-phase return-to-null protocol against the downstream stage's acknowledge. The acknowledge is synchronized internally, and every dual-rail output is driven directly from a flop.

## Interface
- WIDTH, 8 — number of data bits, which is also the number of dual-rail pairs.
- SYNC_STAGES, 2 — flop depth of the ack_in synchronizer; minimum 2.
- TIMEOUT_CYCLES, 255 — watchdog limit; used only when DR_TX_TIMEOUT_EN is defined.

Ports:
- clk  input  1  — clock; all state updates on the rising edge.
- rst  input  1  — asynchronous, active-high reset. The same event drives the async pipeline's rst_n low.
- in_valid  input  1  — word available.
- in_ready  output  1  — bridge can accept a word this cycle.
- in_data  input  WIDTH  — word to send; must be held stable while in_valid && !in_ready.
- dr_out  output  2*WIDTH  — dual-rail word. Bit i is carried as dr_out[2i+1] (true rail) and dr_out[2i] (false rail). The pair 00 means null; 11 is never driven.
- ack_in  input  1  — downstream stage's acknowledge (its ack_ant); asynchronous to clk.
- err  output  1  — sticky watchdog flag.

## Operation
FSM states:
- WAIT_NULL
  - dr_out = 0, in_ready = 0.
  - Moves to IDLE when ack_s == 0, where ack_s is the synchronizer output.
- IDLE
  - dr_out = 0, in_ready = 1.
  - On in_valid, registers the encoding to dr_out: true rail = in_data[i], false rail = ~in_data[i].
  - Moves to WAIT_ACK.
- WAIT_ACK
  - Holds dr_out, in_ready = 0.
  - When ack_s == 1, clears dr_out to 0 and moves to WAIT_NULL.

Reset behaviour:
- Reset enters WAIT_NULL.
- The downstream stage resets holding a DATA0 token with its ack high, so the bridge must first see ack low before the first send.
- Synchronizer flops reset to 1, so no acceptance can happen until a genuine low on ack_in has propagated through them.

Handshake and boundary rules:
- in_valid outside IDLE is ignored.
- A word is consumed only on a clock edge where in_valid && in_ready.
- ack_in is sampled only through the synchronizer and is never used combinationally.
- An ack_in glitch shorter than one clock may be missed. This is harmless because the downstream Muller C-element only changes ack after the data or null wavefront is complete.

Asynchronous reset mid-token:
- dr_out goes to null and in_ready to 0 immediately.
- The in-flight word is dropped, not retried.
- The whole async pipeline is reset by the same event, so no partial token survives downstream.

## Timing
Reset values: dr_out = 0, in_ready = 0, err = 0, state = WAIT_NULL, all synchronizer flops = 1.

Cycle behaviour (acceptance edge = 0, S = SYNC_STAGES):
- dr_out becomes valid one clock after the acceptance edge.
- ack_in is seen in the FSM S edges after it changes.
- dr_out returns to null on the edge after ack_s rises.
- in_ready returns on the edge after ack_s falls.
- With a zero-delay downstream, sustained throughput is one word per 2·S+3 cycles (7 cycles for S = 2).
- dr_out only moves between null and a complete data word on a single clock edge. It never moves directly from one data word to another.

## Configuration
DR_TX_TIMEOUT_EN
- Defined:
  - A counter of width ceil(log2(TIMEOUT_CYCLES+1)) clears on every state entry.
  - It increments each cycle spent in WAIT_ACK or WAIT_NULL.
  - When it reaches TIMEOUT_CYCLES, err is set, and it stays set until rst.
  - The counter saturates at TIMEOUT_CYCLES.
  - The FSM keeps waiting; the watchdog never forces a transition.
- Undefined: no counter; err is tied to 0.

## Test plan
- **Post-reset lockout:** release rst with ack_in held at 1 and in_valid = 1 for 20 cycles → in_ready stays 0 and dr_out = 0. Then drop ack_in → in_ready = 1 exactly S+1 edges later.
- **Single word:** WIDTH = 8, in_data = 8'hA5, downstream model acks after 3 cycles → dr_out = 16'b10011001_01100110 one cycle after acceptance; returns to 0 S+1 edges after ack rises; in_ready reasserts S+1 edges after ack falls.
- **Back-to-back stream:** 32 random words with in_valid held high and a zero-delay ack model → each word is accepted exactly once, in order. Acceptance edges are spaced 2·S+3 cycles apart. No 11 pair and no direct data-to-data transition ever appears on dr_out.
- **Stall:** hold in_valid high with in_data changing while in_ready = 0 → dr_out keeps the latched word; only the value presented at the acceptance edge is sent.
- **Reset mid-token:** assert rst while in WAIT_ACK → dr_out = 0 and in_ready = 0 in the same cycle. After release, the first send waits for ack_in low.
- **Watchdog (DR_TX_TIMEOUT_EN, TIMEOUT_CYCLES = 10):** never assert ack after a send → err rises after 10 cycles in WAIT_ACK and stays high after a late ack completes the handshake. Without the macro, err stays 0.

Source files
------------

// File: rtl/dr_tx_bridge.sv
// dr_tx_bridge: clocked-to-dual-rail injector for the first asynchronous
// dual-rail pipeline stage. Accepts words on a valid/ready handshake, drives
// each bit as a dual-rail pair from a flop, and runs a 4-phase return-to-null
// protocol against a synchronized downstream acknowledge.
//
// Optional feature macro: DR_TX_TIMEOUT_EN
//   defined   -> saturating watchdog counter sets the sticky err flag when the
//                bridge waits TIMEOUT_CYCLES cycles in WAIT_ACK or WAIT_NULL
//   undefined -> no watchdog, err tied low
module dr_tx_bridge #(
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic [2*WIDTH-1:0]   dr_out,
   input  logic                 ack_in,
   output logic                 err
);

   typedef enum logic [1:0] {
      WAIT_NULL = 2'd0,
      IDLE      = 2'd1,
      WAIT_ACK  = 2'd2
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;

   // Dual-rail encoding: true rail carries the bit, false rail its complement.
   function automatic logic [2*WIDTH-1:0] dr_encode(input logic [WIDTH-1:0] d);
      logic [2*WIDTH-1:0] e;
      e = '0;
      for (int i = 0; i < WIDTH; i++) begin
         e[2*i+1] = d[i];
         e[2*i]   = ~d[i];
      end
      return e;
   endfunction

   // Acknowledge synchronizer; flops reset high because the downstream stage
   // comes out of reset holding a token with its ack asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_sync <= '1;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   // Return-to-null handshake FSM; dr_out and in_ready are driven from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= WAIT_NULL;
         dr_out   <= '0;
         in_ready <= 1'b0;
      end else begin
         case (state)
            WAIT_NULL: begin
               if (!ack_s) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end else begin
                  state    <= WAIT_NULL;
               end
            end
            IDLE: begin
               if (in_valid) begin
                  dr_out   <= dr_encode(in_data);
                  in_ready <= 1'b0;
                  state    <= WAIT_ACK;
               end else begin
                  state    <= IDLE;
               end
            end
            WAIT_ACK: begin
               if (ack_s) begin
                  dr_out <= '0;
                  state  <= WAIT_NULL;
               end else begin
                  state  <= WAIT_ACK;
               end
            end
            default: begin
               state    <= WAIT_NULL;
               dr_out   <= '0;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef DR_TX_TIMEOUT_EN
   localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic [CW-1:0] wd_cnt;
   logic          state_move;

   // Flags the edges on which the FSM leaves its current state.
   always_comb begin
      state_move = 1'b0;
      case (state)
         WAIT_NULL: state_move = !ack_s;
         IDLE:      state_move = in_valid;
         WAIT_ACK:  state_move = ack_s;
         default:   state_move = 1'b1;
      endcase
   end

   // Watchdog: counts waiting cycles, clears on state entry, saturates, and
   // latches err when the limit is reached. It never forces a transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else if (state_move) begin
         wd_cnt <= '0;
      end else if ((state != IDLE) && (wd_cnt != LIMIT)) begin
         wd_cnt <= wd_cnt + ONE;
         if (wd_cnt == (LIMIT - ONE)) begin
            err <= 1'b1;
         end else begin
            err <= err;
         end
      end else begin
         wd_cnt <= wd_cnt;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dr_tx_bridge.sv
// Directed self-checking bench for dr_tx_bridge (WIDTH=8, SYNC_STAGES=2,
// TIMEOUT_CYCLES=10). Expected err behaviour follows DR_TX_TIMEOUT_EN.
module tb_dr_tx_bridge;
   localparam int W  = 8;
   localparam int S  = 2;
   localparam int TO = 10;

`ifdef DR_TX_TIMEOUT_EN
   localparam logic WD_EXP = 1'b1;
`else
   localparam logic WD_EXP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic [2*W-1:0] dr_out;
   logic           ack_in;
   logic           err;

   // Downstream model: manual ack, or a zero-delay completion detector.
   logic ack_auto;
   logic ack_man;
   assign ack_in = ack_auto ? (dr_out != '0) : ack_man;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int bad11  = 0;
   int baddd  = 0;
   logic [2*W-1:0] prev_dr;

   always #5 clk = ~clk;

   dr_tx_bridge #(
      .WIDTH(W), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .dr_out(dr_out), .ack_in(ack_in), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] enc(input logic [W-1:0] d);
      logic [2*W-1:0] e;
      e = '0;
      for (int i = 0; i < W; i++) e[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
      return e;
   endfunction

   // One clock; sample 1 ns after the edge and monitor dr_out legality.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < W; i++) if (dr_out[2*i +: 2] == 2'b11) bad11++;
         if (prev_dr != '0 && dr_out != '0 && prev_dr != dr_out) baddd++;
         prev_dr = dr_out;
      end
   endtask

   logic [W-1:0] words [32];
   int           idx;
   int           last;
   logic         acc;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      ack_auto = 1'b0; ack_man = 1'b1; prev_dr = '0;
      #2;
      check("rst_dr", dr_out, 0);
      check("rst_ready", in_ready, 0);
      check("rst_err", err, 0);
      tick(2);

      // Post-reset lockout with downstream ack still high
      rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
      tick(20);
      check("lock_ready", in_ready, 0);
      check("lock_dr", dr_out, 0);
      ack_man = 1'b0;
      tick(S);
      check("lock_ready_S", in_ready, 0);
      tick(1);
      check("lock_ready_S1", in_ready, 1);

      // Single word 8'hA5, downstream acks 3 cycles later
      tick(1);
      check("single_dr", dr_out, 32'(16'b10011001_01100110));
      check("single_ready", in_ready, 0);
      tick(3);
      ack_man = 1'b1; in_valid = 1'b0;
      tick(S);
      check("single_hold", dr_out, 32'(16'b10011001_01100110));
      tick(1);
      check("single_null", dr_out, 0);
      ack_man = 1'b0;
      tick(S);
      check("single_ready_S", in_ready, 0);
      tick(1);
      check("single_ready_S1", in_ready, 1);

      // Back-to-back stream with zero-delay ack
      for (int i = 0; i < 32; i++) words[i] = W'($urandom_range(0, 255));
      ack_auto = 1'b1; idx = 0; last = 0;
      in_valid = 1'b1; in_data = words[0];
      for (int n = 0; n < 400 && idx < 32; n++) begin
         acc = in_ready;
         tick(1);
         if (acc) begin
            check("stream_data", dr_out, 32'(enc(words[idx])));
            if (idx > 0) check("stream_gap", cyc - last, 2*S + 3);
            last = cyc;
            idx++;
            in_data = (idx < 32) ? words[idx] : 8'h00;
         end
      end
      check("stream_count", idx, 32);
      in_valid = 1'b0;
      tick(10);
      ack_auto = 1'b0; ack_man = 1'b0;
      tick(2);
      check("stream_idle", in_ready, 1);

      // Stall: data changes while not ready must not alter the latched word
      in_valid = 1'b1; in_data = 8'h3C;
      tick(1);
      check("stall_dr", dr_out, 32'(enc(8'h3C)));
      for (int k = 0; k < 5; k++) begin
         in_data = W'(k * 37 + 1);
         tick(1);
      end
      check("stall_hold", dr_out, 32'(enc(8'h3C)));
      ack_man = 1'b1; in_data = 8'h81;
      tick(S + 1);
      check("stall_null", dr_out, 0);
      ack_man = 1'b0;
      tick(S + 1);
      check("stall_ready", in_ready, 1);
      check("stall_ignored", dr_out, 0);
      in_data = 8'h42;
      tick(1);
      check("stall_sent", dr_out, 32'(enc(8'h42)));

      // Reset mid-token (in WAIT_ACK)
      rst = 1'b1;
      #1;
      check("midrst_dr", dr_out, 0);
      check("midrst_ready", in_ready, 0);
      tick(2);
      ack_man = 1'b1; rst = 1'b0;
      tick(4);
      check("midrst_lock", in_ready, 0);
      ack_man = 1'b0;
      tick(S + 1);
      check("midrst_ready_back", in_ready, 1);

      // Watchdog: no ack after a send
      in_data = 8'h5A;
      tick(1);
      in_valid = 1'b0;
      check("wd_dr", dr_out, 32'(enc(8'h5A)));
      tick(5);
      check("wd_err_early", err, 0);
      tick(15);
      check("wd_err", err, 32'(WD_EXP));
      ack_man = 1'b1;
      tick(S + 1);
      check("wd_null", dr_out, 0);
      ack_man = 1'b0;
      tick(S + 1);
      check("wd_ready", in_ready, 1);
      check("wd_err_sticky", err, 32'(WD_EXP));

      check("no_11_pair", bad11, 0);
      check("no_data_to_data", baddd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
